// File: rtl/violation_reset_seq_pkg.sv
// Shared definitions for the violation reset sequencer: FSM encodings, monitor source indices.
package violation_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_HDL = 2'd2
    } state_e;

    localparam int NUM_SRC_DEF = 6;
    localparam int CAUSE_W     = 3;

    localparam int SRC_XSTACK     = 0;
    localparam int SRC_AC         = 1;
    localparam int SRC_ATOMICITY  = 2;
    localparam int SRC_DMA_AC     = 3;
    localparam int SRC_DMA_DETECT = 4;
    localparam int SRC_DMA_XSTACK = 5;

endpackage

// File: rtl/violation_reset_seq_prio_enc.sv
// Lowest-index-first priority encoder over the monitor violation vector.
module violation_reset_seq_prio_enc
    import violation_reset_seq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF
) (
    input  logic [NUM_SRC-1:0] viol,
    output logic [CAUSE_W-1:0] idx,
    output logic               valid
);

    // Scan from the top down so the lowest set index is the last to write idx.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (viol[i]) begin
                idx   = CAUSE_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/violation_reset_seq.sv
// Stretches monitor violations into a fixed reset pulse and waits for the core to restart.
// Build option VIOL_LOG_EN: implements the cause/cause_vec/viol_count log; otherwise tied to 0.
module violation_reset_seq
    import violation_reset_seq_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER   = 16'h0000,
    parameter int          HOLD_CYCLES     = 4,
    parameter int          HANDLER_TIMEOUT = 16,
    parameter int          NUM_SRC         = NUM_SRC_DEF,
    parameter int          CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        pc,
    input  logic [NUM_SRC-1:0] viol,
    input  logic               cause_ack,
    output logic               reset,
    output logic [CAUSE_W-1:0] cause,
    output logic               cause_valid,
    output logic [NUM_SRC-1:0] cause_vec,
    output logic [CNT_W-1:0]   viol_count,
    output logic               busy
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TMO_W  = $clog2(HANDLER_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(HANDLER_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              reset_q, reset_d;
    logic              busy_q, busy_d;
    logic              viol_any;
    logic              new_episode;
    logic              first_entry;

    assign viol_any = |viol;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        new_episode = 1'b0;
        first_entry = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (viol_any) begin
                    state_d     = ST_ASSERT;
                    hold_cnt_d  = HOLD_LOAD;
                    new_episode = 1'b1;
                    first_entry = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (hold_cnt_q == '0) begin
                    state_d   = ST_WAIT_HDL;
                    tmo_cnt_d = TMO_LOAD;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            ST_WAIT_HDL: begin
                // A fresh violation beats a simultaneous handler hit.
                if (viol_any || (pc != RESET_HANDLER && tmo_cnt_q == '0)) begin
                    state_d     = ST_ASSERT;
                    hold_cnt_d  = HOLD_LOAD;
                    new_episode = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        reset_d = (state_d == ST_ASSERT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            reset_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            reset_q    <= reset_d;
            busy_q     <= busy_d;
        end
    end

    assign reset = reset_q;
    assign busy  = busy_q;

`ifdef VIOL_LOG_EN
    logic [CAUSE_W-1:0] prio_idx;
    logic               prio_vld;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               cause_valid_q, cause_valid_d;
    logic [NUM_SRC-1:0] cause_vec_q, cause_vec_d;
    logic [CNT_W-1:0]   viol_count_q, viol_count_d;
    logic               valid_after_ack;

    violation_reset_seq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .viol  (viol),
        .idx   (prio_idx),
        .valid (prio_vld)
    );

    // Ack clears first, then a same-cycle violation sets, so a new cause survives an ack.
    always_comb begin
        valid_after_ack = cause_valid_q & ~cause_ack;
        cause_d         = cause_q;
        cause_valid_d   = valid_after_ack;
        cause_vec_d     = (cause_ack ? '0 : cause_vec_q) | viol;
        viol_count_d    = viol_count_q;
        if (first_entry && prio_vld) begin
            cause_valid_d = 1'b1;
            if (!valid_after_ack) begin
                cause_d = prio_idx;
            end
        end
        if (new_episode && viol_count_q != '1) begin
            viol_count_d = viol_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_q       <= '0;
            cause_valid_q <= 1'b0;
            cause_vec_q   <= '0;
            viol_count_q  <= '0;
        end else begin
            cause_q       <= cause_d;
            cause_valid_q <= cause_valid_d;
            cause_vec_q   <= cause_vec_d;
            viol_count_q  <= viol_count_d;
        end
    end

    assign cause       = cause_q;
    assign cause_valid = cause_valid_q;
    assign cause_vec   = cause_vec_q;
    assign viol_count  = viol_count_q;
`else
    logic log_unused;
    assign log_unused  = &{1'b0, cause_ack, new_episode, first_entry};

    assign cause       = '0;
    assign cause_valid = 1'b0;
    assign cause_vec   = '0;
    assign viol_count  = '0;
`endif

endmodule

// File: tb/tb_violation_reset_seq.sv
// Directed bench for violation_reset_seq; log expectations collapse to 0 without VIOL_LOG_EN.
module tb_violation_reset_seq;

`ifdef VIOL_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [5:0]  viol;
    logic        cause_ack;
    logic        reset;
    logic [2:0]  cause;
    logic        cause_valid;
    logic [5:0]  cause_vec;
    logic [7:0]  viol_count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    violation_reset_seq dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .viol        (viol),
        .cause_ack   (cause_ack),
        .reset       (reset),
        .cause       (cause),
        .cause_valid (cause_valid),
        .cause_vec   (cause_vec),
        .viol_count  (viol_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lg(input logic [15:0] v);
        return LOG_EN ? v : 16'h0;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc = 16'hE000; viol = '0; cause_ack = 1'b0;
        step(2);
        check_eq("rst_reset", {15'd0, reset}, 16'd0);
        check_eq("rst_busy", {15'd0, busy}, 16'd0);
        check_eq("rst_cause", {13'd0, cause}, 16'd0);
        check_eq("rst_valid", {15'd0, cause_valid}, 16'd0);
        check_eq("rst_vec", {10'd0, cause_vec}, 16'd0);
        check_eq("rst_count", {8'd0, viol_count}, 16'd0);
        rst = 1'b0;
        step(1);
        $display("reset released: reset=%0d busy=%0d", reset, busy);

        // Single pulse from IDLE: four reset cycles, then handler hit returns to IDLE.
        viol = 6'b000100;
        step(1);
        viol = '0;
        check_eq("t1_reset_rise", {15'd0, reset}, 16'd1);
        check_eq("t1_busy", {15'd0, busy}, 16'd1);
        check_eq("t1_cause", {13'd0, cause}, lg(16'd2));
        check_eq("t1_valid", {15'd0, cause_valid}, lg(16'd1));
        check_eq("t1_vec", {10'd0, cause_vec}, lg(16'h04));
        check_eq("t1_count", {8'd0, viol_count}, lg(16'd1));
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("t1_reset_hold", {15'd0, reset}, 16'd1);
        end
        step(1);
        check_eq("t1_reset_release", {15'd0, reset}, 16'd0);
        check_eq("t1_busy_wait", {15'd0, busy}, 16'd1);
        pc = 16'h0000;
        step(1);
        check_eq("t1_busy_idle", {15'd0, busy}, 16'd0);
        $display("single pulse: cause=%0d count=%0d", cause, viol_count);

        // Clear the log, then a two-source tie with pc parked away from the handler.
        cause_ack = 1'b1;
        step(1);
        cause_ack = 1'b0;
        check_eq("ack_valid", {15'd0, cause_valid}, 16'd0);
        check_eq("ack_vec", {10'd0, cause_vec}, 16'd0);
        pc = 16'hE000;
        viol = 6'b100010;
        step(1);
        viol = '0;
        check_eq("t2_cause", {13'd0, cause}, lg(16'd1));
        check_eq("t2_vec", {10'd0, cause_vec}, lg(16'h22));
        check_eq("t2_count", {8'd0, viol_count}, lg(16'd2));
        $display("tie: cause=%0d vec=%b", cause, cause_vec);

        // Handler never reached: reset reasserts on the 16th cycle after release.
        step(4);
        check_eq("t3_released", {15'd0, reset}, 16'd0);
        step(15);
        check_eq("t3_still_wait", {15'd0, reset}, 16'd0);
        step(1);
        check_eq("t3_reassert", {15'd0, reset}, 16'd1);
        check_eq("t3_count", {8'd0, viol_count}, lg(16'd3));
        check_eq("t3_cause", {13'd0, cause}, lg(16'd1));
        $display("timeout: reset=%0d count=%0d", reset, viol_count);

        // Violation coincides with a handler hit in WAIT_HDL: violation wins.
        step(4);
        check_eq("t4_wait", {15'd0, reset}, 16'd0);
        pc = 16'h0000;
        viol = 6'b000001;
        step(1);
        viol = '0;
        check_eq("t4_reset", {15'd0, reset}, 16'd1);
        check_eq("t4_vec", {10'd0, cause_vec}, lg(16'h23));
        check_eq("t4_count", {8'd0, viol_count}, lg(16'd4));
        check_eq("t4_cause", {13'd0, cause}, lg(16'd1));
        step(4);
        check_eq("t4_busy_wait", {15'd0, busy}, 16'd1);
        step(1);
        check_eq("t4_busy_idle", {15'd0, busy}, 16'd0);
        $display("re-violation: vec=%b count=%0d", cause_vec, viol_count);

        // Ack and a new violation in the same IDLE cycle.
        cause_ack = 1'b1;
        viol = 6'b010000;
        step(1);
        cause_ack = 1'b0;
        viol = '0;
        check_eq("t5_cause", {13'd0, cause}, lg(16'd4));
        check_eq("t5_valid", {15'd0, cause_valid}, lg(16'd1));
        check_eq("t5_vec", {10'd0, cause_vec}, lg(16'h10));
        check_eq("t5_count", {8'd0, viol_count}, lg(16'd5));
        $display("ack race: cause=%0d vec=%b", cause, cause_vec);

        // Asynchronous reset mid-episode, sampled between clock edges.
        step(1);
        check_eq("t6_pre_reset", {15'd0, reset}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_reset", {15'd0, reset}, 16'd0);
        check_eq("t6_async_busy", {15'd0, busy}, 16'd0);
        check_eq("t6_async_count", {8'd0, viol_count}, 16'd0);
        rst = 1'b0;
        step(1);
        $display("async reset: reset=%0d busy=%0d", reset, busy);

        // Saturation of the episode counter.
        for (int i = 1; i <= 300; i++) begin
            viol = 6'b000001;
            step(1);
            viol = '0;
            step(5);
            if (i == 254) check_eq("t6_count_254", {8'd0, viol_count}, lg(16'd254));
            if (i == 255) check_eq("t6_count_255", {8'd0, viol_count}, lg(16'd255));
        end
        check_eq("t6_count_sat", {8'd0, viol_count}, lg(16'd255));
        check_eq("t6_idle", {15'd0, busy}, 16'd0);
        $display("saturation: count=%0d", viol_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
